// File: rtl/fwd_stall_unit.sv
// Operand forwarding and hazard-stall unit for a 5-stage pipeline.
// Tracks EXE/MEM destinations, selects per-channel bypass sources and raises load-use/interlock stalls.
module fwd_stall_unit #(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned AW      = 5,
  parameter int unsigned DW      = 32,
  parameter int unsigned FWD_EN  = 1
) (
  input  logic                  clk,
  input  logic                  clrn,
  input  logic [NUM_SRC*AW-1:0] id_rs,
  input  logic [NUM_SRC-1:0]    id_use,
  input  logic                  id_valid,
  input  logic                  id_wreg,
  input  logic                  id_m2reg,
  input  logic [AW-1:0]         id_rd,
  input  logic                  flush,
  input  logic [NUM_SRC*DW-1:0] q,
  input  logic [DW-1:0]         exe_r,
  input  logic [DW-1:0]         mem_r,
  input  logic [DW-1:0]         mem_mdo,
  output logic [NUM_SRC*2-1:0]  fwd_sel,
  output logic [NUM_SRC*DW-1:0] fwd_data,
  output logic                  stall,
  output logic [15:0]           stall_cnt
);

  localparam int unsigned CW = 16;
  localparam logic [1:0] SEL_Q   = 2'b00;
  localparam logic [1:0] SEL_EXE = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_MDO = 2'b11;

  logic          r_e_valid;
  logic          r_e_wreg;
  logic          r_e_m2reg;
  logic [AW-1:0] r_e_rd;
  logic          r_m_valid;
  logic          r_m_wreg;
  logic          r_m_m2reg;
  logic [AW-1:0] r_m_rd;
  logic [CW-1:0] r_stall_cnt;

  logic [NUM_SRC-1:0]    w_e_hit;
  logic [NUM_SRC-1:0]    w_m_hit;
  logic [NUM_SRC-1:0]    w_hz;
  logic [NUM_SRC*2-1:0]  w_sel;
  logic [NUM_SRC*DW-1:0] w_data;
  logic                  w_stall;
  logic [CW-1:0]         w_cnt_nxt;

  // Per-channel destination match against EXE and MEM; r0 and unused sources never match.
  always_comb begin : hit_detect
    w_e_hit = '0;
    w_m_hit = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (id_use[i] && (id_rs[i*AW +: AW] != '0)) begin
        w_e_hit[i] = r_e_valid && r_e_wreg && (r_e_rd == id_rs[i*AW +: AW]);
        w_m_hit[i] = r_m_valid && r_m_wreg && (r_m_rd == id_rs[i*AW +: AW]);
      end
    end
  end

  // Source selection and per-channel hazard; EXE match shadows any MEM match.
  always_comb begin : sel_hazard
    w_sel = '0;
    w_hz  = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (FWD_EN != 0) begin
        if (w_e_hit[i]) begin
          if (r_e_m2reg) begin
            w_hz[i] = 1'b1;
          end else begin
            w_sel[2*i +: 2] = SEL_EXE;
          end
        end else if (w_m_hit[i]) begin
          w_sel[2*i +: 2] = r_m_m2reg ? SEL_MDO : SEL_MEM;
        end
      end else begin
        w_hz[i] = w_e_hit[i] | w_m_hit[i];
      end
    end
  end

  always_comb begin : data_mux
    w_data = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      case (w_sel[2*i +: 2])
        SEL_EXE: w_data[i*DW +: DW] = exe_r;
        SEL_MEM: w_data[i*DW +: DW] = mem_r;
        SEL_MDO: w_data[i*DW +: DW] = mem_mdo;
        default: w_data[i*DW +: DW] = q[i*DW +: DW];
      endcase
    end
  end

  // A killed or empty ID slot can never stall.
  assign w_stall   = id_valid && !flush && (|w_hz);
  assign w_cnt_nxt = (w_stall && (r_stall_cnt != '1)) ? r_stall_cnt + CW'(1) : r_stall_cnt;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_e_valid   <= 1'b0;
      r_e_wreg    <= 1'b0;
      r_e_m2reg   <= 1'b0;
      r_e_rd      <= '0;
      r_m_valid   <= 1'b0;
      r_m_wreg    <= 1'b0;
      r_m_m2reg   <= 1'b0;
      r_m_rd      <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_m_valid   <= r_e_valid;
      r_m_wreg    <= r_e_wreg;
      r_m_m2reg   <= r_e_m2reg;
      r_m_rd      <= r_e_rd;
      r_e_valid   <= id_valid && !flush && !w_stall;
      r_e_wreg    <= id_wreg;
      r_e_m2reg   <= id_m2reg;
      r_e_rd      <= id_rd;
      r_stall_cnt <= w_cnt_nxt;
    end
  end

  assign fwd_sel   = w_sel;
  assign fwd_data  = w_data;
  assign stall     = w_stall;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: doc/fwd_stall_unit.md
FWD_STALL_UNIT -- requirements
Module: fwd_stall_unit

Interface
REQ-001 The block SHALL have parameter NUM_SRC, default 2: number of source-operand channels in ID.
REQ-002 The block SHALL have parameter AW, default 5: register-address width.
REQ-003 The block SHALL have parameter DW, default 32: data width.
REQ-004 The block SHALL have parameter FWD_EN, default 1: 1 = forwarding plus load-use stall; 0 = interlock only, with no forwarding.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port clrn, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port id_rs, input, NUM_SRC*AW bits: source register numbers; channel i occupies [i*AW +: AW].
REQ-008 The block SHALL have port id_use, input, NUM_SRC bits: channel i actually reads its source.
REQ-009 The block SHALL have ports id_valid, id_wreg, id_m2reg, inputs, 1 bit each: ID holds a live instruction; it writes a register; it is a load.
REQ-010 The block SHALL have port id_rd, input, AW bits: ID destination register.
REQ-011 The block SHALL have port flush, input, 1 bit: kill the ID instruction (branch taken).
REQ-012 The block SHALL have port q, input, NUM_SRC*DW bits: register-file read data per channel.
REQ-013 The block SHALL have ports exe_r, mem_r and mem_mdo, inputs, DW bits each: ALU result in EXE; ALU result held in MEM; data-memory output in MEM.
REQ-014 The block SHALL have port fwd_sel, output, NUM_SRC*2 bits: per-channel select, where 00 = q, 01 = exe_r, 10 = mem_r and 11 = mem_mdo.
REQ-015 The block SHALL have port fwd_data, output, NUM_SRC*DW bits: per-channel operand selected by fwd_sel.
REQ-016 The block SHALL have port stall, output, 1 bit: hold PC and IF/ID, and insert a bubble into EXE.
REQ-017 The block SHALL have port stall_cnt, output, 16 bits: saturating count of stalled cycles.

Function
REQ-018 The block SHALL keep internal EXE tracking state {e_valid, e_wreg, e_m2reg, e_rd} and MEM tracking state {m_valid, m_wreg, m_m2reg, m_rd}.
REQ-019 Each cycle the MEM tracking state SHALL load the EXE tracking state.
REQ-020 Each cycle the EXE tracking state SHALL load the ID fields, with e_valid = id_valid & ~flush & ~stall.
REQ-021 When the EXE tracking state loads a bubble (e_valid = 0), its other EXE fields are don't-care.
REQ-022 A stage SHALL match channel i when all hold: stage valid, stage wreg, stage rd == rs_i, rs_i != 0 and id_use[i] = 1.
REQ-023 Register 0 SHALL never be forwarded and SHALL never cause a stall.
REQ-024 With FWD_EN = 1, a channel matching EXE with e_m2reg = 0 SHALL select 01.
REQ-025 With FWD_EN = 1, a channel that does not hit REQ-024, does not match EXE, and matches MEM SHALL select 10 if m_m2reg = 0, else 11.
REQ-026 With FWD_EN = 1, all remaining channels SHALL select 00.
REQ-027 EXE SHALL take priority over MEM when both match.
REQ-028 With FWD_EN = 1, stall SHALL be 1 when any channel matches EXE with e_m2reg = 1 (load-use); the stall lasts exactly 1 cycle, after which the channel selects 11.
REQ-029 With FWD_EN = 0, fwd_sel SHALL always be 00.
REQ-030 With FWD_EN = 0, stall SHALL be 1 while any channel matches EXE or MEM; this gives up to 2 stall cycles, and the instruction then reads q (write-before-read register file).
REQ-031 stall, fwd_sel and fwd_data SHALL be combinational from the current state and inputs, with zero latency.
REQ-032 stall SHALL be 0 when id_valid = 0 or flush = 1.
REQ-033 stall_cnt SHALL increment on every cycle with stall = 1 and SHALL hold at 16'hFFFF.
REQ-034 Simultaneous flush and hazard: flush SHALL win, stall = 0, and a bubble enters EXE.

Reset
REQ-035 When clrn = 0, all valid bits and stall_cnt SHALL clear immediately, asynchronously.
REQ-036 After reset, stall = 0 and every fwd_sel = 00, so fwd_data = q.
REQ-037 A reset asserted mid-stall SHALL drop stall in the same cycle, and no pending hazard SHALL survive the reset.

Verification
REQ-038 ALU forward test (FWD_EN = 1): add r3 issued, then next ID uses rs0 = 3 -> fwd_sel[1:0] = 01, fwd_data = exe_r, stall = 0.
REQ-039 Priority and MEM forward test: r3 written in both EXE and MEM -> select 01. With only the MEM copy -> 10. With the MEM copy being a load -> 11 and fwd_data = mem_mdo.
REQ-040 Load-use test: lw r5, then next ID uses rs1 = 5 -> stall = 1 for exactly 1 cycle, stall_cnt 0 -> 1, then select 11.
REQ-041 r0 and flush test: lw r0 followed by a use of r0 -> no stall, select 00. A hazard together with flush = 1 -> stall = 0, and the next cycle shows no EXE match.
REQ-042 Interlock and saturation test (FWD_EN = 0): add r7 followed by a use of r7 -> stall for 2 cycles, fwd_sel stays 00. Preload stall_cnt to FFFE and stall for 3 cycles -> stall_cnt ends at FFFF.
REQ-043 Reset test: assert clrn = 0 asynchronously during a load-use stall -> stall = 0 and stall_cnt = 0 before the next clk edge.
